// File: rtl/arm_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   - arb_state_e : arbiter FSM state encoding (IDLE / BUSY / DONE)
//   - gnt_e       : which requester owns the current access (IF or MEM)
//   - DEFAULT_WAIT_CYCLES : default memory access latency in cycles
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  localparam int DEFAULT_WAIT_CYCLES = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between the fetch stage (IF)
// and the memory stage (MEM). MEM has fixed priority over IF.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   if_req, if_addr           fetch read request (held until if_ready)
//   if_rdata, if_ready        registered fetch data, one-cycle completion pulse
//   if_stall                  if_req & ~if_ready
//   mem_r_en, mem_w_en        load / store request (held until mem_ready)
//   mem_addr, mem_wdata       load/store address and store data
//   mem_rdata, mem_ready      registered load data, one-cycle completion pulse
//   mem_stall                 (mem_r_en | mem_w_en) & ~mem_ready
//   sram_addr, sram_wdata     memory address / write data (driven in BUSY only)
//   sram_we, sram_oe          memory write / read strobes (BUSY only)
//   sram_rdata                memory read data, valid in the last BUSY cycle
//
// Handshake: a requester raises its request and holds it (with stable
// address/data) until its ready pulse. The ready pulse lasts exactly one
// cycle (DONE state) and only for the granted requester. Address and data are
// latched at grant, so later input changes or a withdrawn request do not
// affect an access that has already started.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Counter runs WAIT_CYCLES-1 down to 0, one BUSY cycle per count value.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  arb_state_e        state, state_next;
  logic [3:0]        cnt, cnt_next;
  gnt_e              gnt, gnt_next;
  logic              grant_load;
  logic              cap_if, cap_mem;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              mem_req;
  logic              busy;

  assign mem_req = mem_r_en | mem_w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      gnt       <= GNT_IF;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      gnt   <= gnt_next;
      if (grant_load) begin
        lat_addr  <= (gnt_next == GNT_MEM) ? mem_addr : if_addr;
        lat_wdata <= mem_wdata;
        lat_we    <= (gnt_next == GNT_MEM) && mem_w_en;
      end
      if (cap_if)  if_rdata  <= sram_rdata;
      if (cap_mem) mem_rdata <= sram_rdata;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gnt_next   = gnt;
    grant_load = 1'b0;
    cap_if     = 1'b0;
    cap_mem    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (mem_req) begin
          grant_load = 1'b1;
          gnt_next   = GNT_MEM;
          cnt_next   = CNT_LOAD;
          state_next = ARB_BUSY;
        end else if (if_req) begin
          grant_load = 1'b1;
          gnt_next   = GNT_IF;
          cnt_next   = CNT_LOAD;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (cnt == 4'd0) begin
          state_next = ARB_DONE;
          // Last BUSY cycle: read data is valid, capture for the owner only.
          if (!lat_we) begin
            cap_if  = (gnt == GNT_IF);
            cap_mem = (gnt == GNT_MEM);
          end
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Memory-side outputs are forced to zero outside BUSY so the bus is quiet
  // in IDLE/DONE and immediately after reset.
  always_comb begin
    busy       = (state == ARB_BUSY);
    sram_addr  = busy ? lat_addr : '0;
    sram_wdata = (busy && lat_we) ? lat_wdata : '0;
    sram_we    = busy && lat_we;
    sram_oe    = busy && !lat_we;
    if_ready   = (state == ARB_DONE) && (gnt == GNT_IF);
    mem_ready  = (state == ARB_DONE) && (gnt == GNT_MEM);
  end

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int W  = 3;
  localparam int W1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        if_req, mem_r_en, mem_w_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;

  // DUT with W=3
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        if_ready, if_stall, mem_ready, mem_stall, sram_we, sram_oe;
  // DUT with W=1
  logic [31:0] if_rdata_b, mem_rdata_b, sram_addr_b, sram_wdata_b, sram_rdata_b;
  logic        if_ready_b, if_stall_b, mem_ready_b, mem_stall_b, sram_we_b, sram_oe_b;

  logic [31:0] sram   [0:255];
  logic [31:0] sram_b [0:255];

  assign sram_rdata   = sram[sram_addr[9:2]];
  assign sram_rdata_b = sram_b[sram_addr_b[9:2]];
  always @(posedge clk) if (sram_we)   sram[sram_addr[9:2]]     <= sram_wdata;
  always @(posedge clk) if (sram_we_b) sram_b[sram_addr_b[9:2]] <= sram_wdata_b;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_stall(mem_stall),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_oe(sram_oe), .sram_rdata(sram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_b),
    .if_ready(if_ready_b), .if_stall(if_stall_b),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata_b), .mem_ready(mem_ready_b),
    .mem_stall(mem_stall_b),
    .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b), .sram_we(sram_we_b),
    .sram_oe(sram_oe_b), .sram_rdata(sram_rdata_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_if_rdata, exp_mem_rdata;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One access by one requester, started in an IDLE cycle. Cycle numbers
  // count from the first edge that sees the request (cycle 1 = after it).
  // Returns in the IDLE cycle that follows DONE.
  task automatic do_access(input bit is_mem, input bit is_wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           output int rdy, output int strobes,
                           output bit bus_bad, output bit spurious);
    rdy = -1; strobes = 0; bus_bad = 1'b0; spurious = 1'b0;
    if_req    = !is_mem;
    if_addr   = addr;
    mem_r_en  = is_mem && !is_wr;
    mem_w_en  = is_mem && is_wr;
    mem_addr  = addr;
    mem_wdata = data;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (is_wr ? sram_we : sram_oe) begin
        strobes++;
        if (sram_addr !== addr || (is_wr && sram_wdata !== data)) bus_bad = 1'b1;
      end
      if (is_wr ? sram_oe : sram_we) bus_bad = 1'b1;
      if (is_mem ? if_ready : mem_ready) spurious = 1'b1;
      if (is_mem ? mem_ready : if_ready) begin
        rdy = c;
        break;
      end
    end
    idle_inputs();
    tick();
    if (if_ready || mem_ready) spurious = 1'b1;
  endtask

  // MEM and IF requests raised together; each is dropped at its own ready.
  task automatic do_pair(input bit m_wr, input logic [31:0] m_addr,
                         input logic [31:0] m_data, input logic [31:0] i_addr,
                         output int m_rdy, output int i_rdy, output bit stall_bad);
    m_rdy = -1; i_rdy = -1; stall_bad = 1'b0;
    if_req    = 1'b1;
    if_addr   = i_addr;
    mem_r_en  = !m_wr;
    mem_w_en  = m_wr;
    mem_addr  = m_addr;
    mem_wdata = m_data;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c <= 2 * W + 2 && if_stall !== 1'b1) stall_bad = 1'b1;
      if (c <= W && mem_stall !== 1'b1) stall_bad = 1'b1;
      if (mem_ready) begin
        m_rdy = c;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
      end
      if (if_ready) begin
        i_rdy = c;
        break;
      end
    end
    idle_inputs();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int rdy, st; bit bb, sp, seen;
    apply_reset();
    n_checks++;
    if ({if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
         sram_addr, sram_wdata, sram_we, sram_oe} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: outputs %h expected all zero",
               {if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
                sram_addr, sram_wdata, sram_we, sram_oe});
    end
    sram[8'h10] = 32'h1111_2222;
    sram[8'h11] = 32'h3333_4444;
    do_access(1'b0, 1'b0, 32'h40, 32'h0, rdy, st, bb, sp);
    n_checks++;
    if (if_rdata !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL reset_pre_read: if_rdata %h expected %h", if_rdata, 32'h1111_2222);
    end
    if_req = 1'b1;
    if_addr = 32'h44;
    tick();
    tick();
    #2;
    rst = 1'b1;
    if_req = 1'b0;
    #1;
    n_checks++;
    if ({if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
         sram_addr, sram_wdata, sram_we, sram_oe} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: outputs %h expected all zero",
               {if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
                sram_addr, sram_wdata, sram_we, sram_oe});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (if_ready || mem_ready || sram_oe || sram_we) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || if_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_no_ready: activity %0b if_rdata %h expected 0 and 0", seen, if_rdata);
    end
  endtask

  task automatic test_if_read();
    int rdy, st; bit bb, sp;
    apply_reset();
    sram[8'h10] = 32'hE3A0_0005;
    do_access(1'b0, 1'b0, 32'h40, 32'h0, rdy, st, bb, sp);
    n_checks++;
    if (rdy !== W + 1) begin
      n_fail++;
      $display("FAIL if_read_latency: ready at cycle %0d expected %0d", rdy, W + 1);
    end
    n_checks++;
    if (st !== W || bb !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_bus: oe cycles %0d bus_err %0b expected %0d and 0", st, bb, W);
    end
    n_checks++;
    if (sp !== 1'b0) begin
      n_fail++;
      $display("FAIL if_read_pulse: spurious/long ready %0b expected 0", sp);
    end
    n_checks++;
    if (if_rdata !== 32'hE3A0_0005) begin
      n_fail++;
      $display("FAIL if_read_data: if_rdata %h expected %h", if_rdata, 32'hE3A0_0005);
    end
  endtask

  task automatic test_mem_write();
    int rdy, st; bit bb, sp;
    apply_reset();
    sram[8'h80] = 32'hCAFE_F00D;
    do_access(1'b1, 1'b0, 32'h200, 32'h0, rdy, st, bb, sp);
    n_checks++;
    if (mem_rdata !== 32'hCAFE_F00D || rdy !== W + 1) begin
      n_fail++;
      $display("FAIL mem_load: mem_rdata %h ready %0d expected %h and %0d",
               mem_rdata, rdy, 32'hCAFE_F00D, W + 1);
    end
    do_access(1'b1, 1'b1, 32'h400, 32'h1234_5678, rdy, st, bb, sp);
    n_checks++;
    if (rdy !== W + 1 || sp !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_write_latency: ready %0d spurious %0b expected %0d and 0", rdy, sp, W + 1);
    end
    n_checks++;
    if (st !== W || bb !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_write_bus: we cycles %0d bus_err %0b expected %0d and 0", st, bb, W);
    end
    n_checks++;
    if (sram[8'h00] !== 32'h1234_5678 || mem_rdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL mem_write_effect: sram %h mem_rdata %h expected %h and %h",
               sram[8'h00], mem_rdata, 32'h1234_5678, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_simultaneous();
    int mr, ir; bit sb;
    apply_reset();
    sram[8'h10] = 32'hAAAA_0001;
    sram[8'hC0] = 32'hBBBB_0002;
    do_pair(1'b0, 32'h300, 32'h0, 32'h40, mr, ir, sb);
    n_checks++;
    if (mr !== W + 1 || ir !== 2 * W + 3) begin
      n_fail++;
      $display("FAIL simul_order: mem_ready %0d if_ready %0d expected %0d and %0d",
               mr, ir, W + 1, 2 * W + 3);
    end
    n_checks++;
    if (sb !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_stall: stall error %0b expected 0", sb);
    end
    n_checks++;
    if (mem_rdata !== 32'hBBBB_0002 || if_rdata !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL simul_data: mem_rdata %h if_rdata %h expected %h and %h",
               mem_rdata, if_rdata, 32'hBBBB_0002, 32'hAAAA_0001);
    end
  endtask

  task automatic test_flush();
    int ir, mr; bit addr_bad;
    apply_reset();
    sram[8'h10] = 32'h0F0F_1234;
    sram[8'h20] = 32'hDEAD_0080;
    sram[8'h40] = 32'h5555_0100;
    ir = -1; mr = -1; addr_bad = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h40;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c <= W && sram_addr !== 32'h40) addr_bad = 1'b1;
      if (c == 2) begin
        if_req = 1'b0;
        if_addr = 32'h80;
      end
      if (c == 3) begin
        mem_r_en = 1'b1;
        mem_addr = 32'h100;
      end
      if (if_ready) ir = c;
      if (mem_ready) begin
        mr = c;
        break;
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (addr_bad !== 1'b0 || if_rdata !== 32'h0F0F_1234) begin
      n_fail++;
      $display("FAIL flush_latched: addr_err %0b if_rdata %h expected 0 and %h",
               addr_bad, if_rdata, 32'h0F0F_1234);
    end
    n_checks++;
    if (ir !== W + 1 || mr !== 2 * W + 3) begin
      n_fail++;
      $display("FAIL flush_timing: if_ready %0d mem_ready %0d expected %0d and %0d",
               ir, mr, W + 1, 2 * W + 3);
    end
  endtask

  task automatic test_back_to_back();
    int r1, r2; logic [31:0] d1, d2;
    apply_reset();
    sram_b[8'h00] = 32'h0101_0101;
    sram_b[8'h01] = 32'h0202_0202;
    r1 = -1; r2 = -1; d1 = 32'h0; d2 = 32'h0;
    mem_r_en = 1'b1;
    mem_addr = 32'h400;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (mem_ready_b) begin
        if (r1 < 0) begin
          r1 = c;
          d1 = mem_rdata_b;
          mem_addr = 32'h404;
        end else begin
          r2 = c;
          d2 = mem_rdata_b;
          break;
        end
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if (r1 !== W1 + 1 || r2 !== 2 * W1 + 3) begin
      n_fail++;
      $display("FAIL b2b_timing: ready cycles %0d,%0d expected %0d,%0d",
               r1, r2, W1 + 1, 2 * W1 + 3);
    end
    n_checks++;
    if (d1 !== 32'h0101_0101 || d2 !== 32'h0202_0202) begin
      n_fail++;
      $display("FAIL b2b_data: %h,%h expected %h,%h", d1, d2, 32'h0101_0101, 32'h0202_0202);
    end
  endtask

  task automatic test_random();
    int rdy, st, mr, ir, kind; bit bb, sp, sb, mw;
    logic [7:0]  ai, mi;
    logic [31:0] d, e;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    apply_reset();
    exp_if_rdata  = 32'h0;
    exp_mem_rdata = 32'h0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      ai   = 8'($urandom_range(0, 15));
      mi   = 8'($urandom_range(0, 15));
      d    = $urandom;
      if (kind == 3) begin
        mw = 1'($urandom_range(0, 1));
        if (mw) ref_mem[mi] = d;
        else    exp_mem_rdata = ref_mem[mi];
        exp_if_rdata = ref_mem[ai];
        do_pair(mw, {22'h0, mi, 2'b00}, d, {22'h0, ai, 2'b00}, mr, ir, sb);
        n_checks++;
        if (mr !== W + 1 || ir !== 2 * W + 3 || sb !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_pair[%0d]: mem %0d if %0d stall_err %0b expected %0d %0d 0",
                   it, mr, ir, sb, W + 1, 2 * W + 3);
        end
      end else begin
        if (kind == 2) ref_mem[mi] = d;
        else exp_q.push_back(ref_mem[(kind == 0) ? ai : mi]);
        do_access(kind != 0, kind == 2, {22'h0, ((kind == 0) ? ai : mi), 2'b00}, d,
                  rdy, st, bb, sp);
        n_checks++;
        if (rdy !== W + 1 || st !== W || bb !== 1'b0 || sp !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_access[%0d] kind %0d: ready %0d strobes %0d bus %0b spur %0b expected %0d %0d 0 0",
                   it, kind, rdy, st, bb, sp, W + 1, W);
        end
        if (kind != 2) begin
          e = exp_q.pop_front();
          if (kind == 0) exp_if_rdata = e;
          else           exp_mem_rdata = e;
        end
      end
      n_checks++;
      if (if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin
        n_fail++;
        $display("FAIL rand_rdata[%0d]: if %h mem %h expected %h %h",
                 it, if_rdata, mem_rdata, exp_if_rdata, exp_mem_rdata);
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (sram[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL rand_mem_image[%0d]: %h expected %h", i, sram[i], ref_mem[i]);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence / report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 32'h0;
      sram_b[i]  = 32'h0;
      ref_mem[i] = 32'h0;
    end
    test_reset();
    test_if_read();
    test_mem_write();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency instruction/data memory between the instruction fetch stage and the memory stage of the 5-stage pipeline. Each request is granted under fixed priority, with the memory stage ranked above fetch. The block drives the memory for exactly `WAIT_CYCLES` cycles per access, registers read data, and returns a one-cycle ready pulse. It also produces per-requester stall signals, which the top level ORs into the pipeline freeze logic.

## Interface
Parameters:
- `ADDR_W`, 32, address width (byte address, passed through unmodified).
- `DATA_W`, 32, data word width.
- `WAIT_CYCLES`, 3, cycles the memory needs per access; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  fetch read request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word; registered.
- `if_ready`  out  1  one-cycle pulse when the fetch access completes.
- `if_stall`  out  1  `if_req & ~if_ready`.
- `mem_r_en`  in  1  load request; held until `mem_ready`.
- `mem_w_en`  in  1  store request; held until `mem_ready`. Never asserted together with `mem_r_en`.
- `mem_addr`  in  ADDR_W  load/store address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_rdata`  out  DATA_W  loaded word; registered.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_stall`  out  1  `(mem_r_en|mem_w_en) & ~mem_ready`.
- `sram_addr`  out  ADDR_W  memory address.
- `sram_wdata`  out  DATA_W  memory write data.
- `sram_we`  out  1  memory write enable.
- `sram_oe`  out  1  memory read enable.
- `sram_rdata`  in  DATA_W  memory read data; valid in the last BUSY cycle.

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE:** if `mem_r_en|mem_w_en`, grant MEM; else if `if_req`, grant IF; else stay in IDLE. On a grant, latch the grant, address, write data and read/write direction, load `cnt = WAIT_CYCLES-1`, and go to BUSY.
- **BUSY:**
  - `sram_addr`/`sram_wdata` drive the latched values.
  - `sram_we=1` for writes; `sram_oe=1` for reads.
  - `cnt` decrements each cycle. When `cnt==0`: on a read, capture `sram_rdata` into the granted requester's rdata register; go to DONE.
- **DONE:** pulse `if_ready` or `mem_ready` (granted requester only); all sram strobes 0; requests are ignored this cycle; go to IDLE.
- Address/data are latched at grant; input changes during BUSY have no effect.
- A request withdrawn mid-access (e.g. pipeline flush) does not abort the access. It still completes and the ready pulse still fires; the requester ignores it.
- A write completion does not change `mem_rdata`. Each rdata register holds until its next read completion.
- Stall outputs are combinational from the request inputs and the registered ready pulses. No ready pulse ever appears without a grant.
- Reset at any time:
  - state becomes IDLE, `cnt` becomes 0, grant is cleared;
  - all outputs are 0, including both rdata registers and the sram strobes;
  - an interrupted write may be partially applied, and this is acceptable.

## Timing
- Request first seen in IDLE at edge 0:
  - BUSY covers cycles 1..W;
  - DONE is cycle W+1, so ready is high in cycle W+1;
  - IDLE again at cycle W+2.
- The per-access period is W+2 cycles.
- For back-to-back accesses the next grant is evaluated at cycle W+2, giving exactly one idle cycle between accesses.
- Simultaneous IF and MEM requests:
  - MEM ready at cycle W+1;
  - IF granted at cycle W+2, IF ready at cycle 2W+3.
- With `WAIT_CYCLES=1`: one BUSY cycle, ready at cycle 2.
- Fixed priority is sufficient: a pending MEM request always belongs to an older instruction, and fetch must advance for new MEM requests to occur, so IF cannot starve indefinitely.

## Structure
- Shared package `arm_mem_pkg` holds:
  - state encoding `ARB_IDLE=2'd0`, `ARB_BUSY=2'd1`, `ARB_DONE=2'd2`;
  - grant encoding `GNT_IF=1'b0`, `GNT_MEM=1'b1`;
  - `DEFAULT_WAIT_CYCLES=3`.
- The block is a single module. The counter and FSM are inline; no sub-module.

## Test plan
- **Reset:** assert `rst` mid-BUSY with W=3 -> all outputs 0 in the same cycle; state IDLE; no ready pulse after release.
- **IF read:** `if_req=1`, `if_addr=0x40`, memory returns `0xE3A00005` -> `sram_oe=1` for 3 cycles; `if_ready` pulse at cycle 4; `if_rdata=0xE3A00005`.
- **MEM write:** `mem_w_en=1`, `mem_addr=0x400`, `mem_wdata=0x12345678` -> `sram_we=1` for cycles 1..3; `mem_ready` at cycle 4; `mem_rdata` unchanged.
- **Simultaneous:** `if_req` and `mem_r_en` both asserted at cycle 0 -> `mem_ready` at cycle 4; `if_stall=1` through cycle 8; `if_ready` at cycle 9.
- **Flush:** `if_req` dropped at cycle 2 and `if_addr` changed -> `sram_addr` stays 0x40; `if_ready` pulse at cycle 4; next grant evaluated at cycle 5.
- **Back-to-back loads:** two loads with W=1 (addresses 0x400, 0x404) -> ready at cycles 2 and 5; `mem_rdata` updated each time.
